// File: rtl/sccb_config_sequencer_if.sv
// rtl/sccb_config_sequencer_if.sv - start/table/SCCB/status bundle of the configuration sequencer
interface sccb_config_sequencer_if;
  logic        start;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic        sio_c;
  logic        sio_d_oe;
  logic        busy;
  logic        done;

  modport master (
    input  start, rom_data,
    output rom_addr, sio_c, sio_d_oe, busy, done
  );

  modport slave (
    output start, rom_data,
    input  rom_addr, sio_c, sio_d_oe, busy, done
  );
endinterface

// File: rtl/sccb_config_sequencer.sv
// rtl/sccb_config_sequencer.sv - walks a {reg_addr, reg_value} table and issues one SCCB 3-phase write per entry
// Optional macro CFG_DELAY_EN: entry 16'hFFF0 becomes a DELAY_CYCLES idle pause instead of a write.
module sccb_config_sequencer #(
  parameter int         CLK_DIV      = 63,
  parameter logic [7:0] DEV_ADDR     = 8'h42,
  parameter int         DELAY_CYCLES = 250000
) (
  input logic                     clk_25,
  input logic                     reset,
  sccb_config_sequencer_if.master bus
);
  localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  if (CLK_DIV < 2) begin : g_bad_div
    $error("CLK_DIV must be at least 2");
  end
  if (DELAY_CYCLES < 1) begin : g_bad_delay
    $error("DELAY_CYCLES must be at least 1");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_CHECK, S_START, S_SEND, S_STOP, S_GAP,
`ifdef CFG_DELAY_EN
    S_DELAY,
`endif
    S_FINISH
  } state_t;

  state_t      state_q, state_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [1:0]  phase_q, phase_d;
  logic [4:0]  bit_q, bit_d;
  logic [26:0] frame_q, frame_d;
  logic [7:0]  addr_q, addr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        sio_c_q, sio_c_d;
  logic        oe_q, oe_d;
  logic        q_last, ph_last, entry_end;
`ifdef CFG_DELAY_EN
  localparam int DW = $clog2(DELAY_CYCLES + 1);
  logic [DW-1:0] dcnt_q, dcnt_d;
`endif

  assign q_last  = (qcnt_q == QW'(CLK_DIV - 1));
  assign ph_last = q_last && (phase_q == 2'd3);

  // Bus levels per state/quarter, returned as {scl, sda_drive_low}.
  function automatic logic [1:0] bus_drive(state_t st, logic [1:0] ph, logic msb);
    case (st)
      S_START: bus_drive = {ph < 2'd2, ph != 2'd0};
      S_SEND:  bus_drive = {ph[1], ~msb};
      S_STOP:  bus_drive = {ph != 2'd0, ph < 2'd2};
      default: bus_drive = 2'b10;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    qcnt_d    = qcnt_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    frame_d   = frame_q;
    addr_d    = addr_q;
    busy_d    = busy_q;
    done_d    = done_q;
    entry_end = 1'b0;
`ifdef CFG_DELAY_EN
    dcnt_d    = dcnt_q;
`endif

    if (state_q == S_START || state_q == S_SEND || state_q == S_STOP || state_q == S_GAP) begin
      qcnt_d = q_last ? '0 : qcnt_q + QW'(1);
      if (q_last) phase_d = phase_q + 2'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          addr_d  = 8'd0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_CHECK;
      S_CHECK: begin
        qcnt_d  = '0;
        phase_d = 2'd0;
        bit_d   = 5'd0;
        if (bus.rom_data == 16'hFFFF) begin
          state_d = S_FINISH;
`ifdef CFG_DELAY_EN
        end else if (bus.rom_data == 16'hFFF0) begin
          dcnt_d  = '0;
          state_d = S_DELAY;
`endif
        end else begin
          frame_d = {DEV_ADDR, 1'b1, bus.rom_data[15:8], 1'b1, bus.rom_data[7:0], 1'b1};
          state_d = S_START;
        end
      end
      S_START: if (ph_last) state_d = S_SEND;
      S_SEND: begin
        if (ph_last) begin
          frame_d = {frame_q[25:0], 1'b1};
          if (bit_q == 5'd26) state_d = S_STOP;
          else                bit_d   = bit_q + 5'd1;
        end
      end
      S_STOP: if (ph_last) state_d = S_GAP;
      S_GAP:  entry_end = ph_last;
`ifdef CFG_DELAY_EN
      S_DELAY: begin
        dcnt_d    = dcnt_q + DW'(1);
        entry_end = (dcnt_q == DW'(DELAY_CYCLES - 1));
      end
`endif
      S_FINISH: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Entry 255 is the last one; the address saturates rather than wrapping.
    if (entry_end) begin
      if (addr_q == 8'hFF) begin
        state_d = S_FINISH;
      end else begin
        addr_d  = addr_q + 8'd1;
        state_d = S_FETCH;
      end
    end

    {sio_c_d, oe_d} = bus_drive(state_d, phase_d, frame_d[26]);
  end

  always_ff @(posedge clk_25 or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      qcnt_q  <= '0;
      phase_q <= 2'd0;
      bit_q   <= 5'd0;
      frame_q <= '1;
      addr_q  <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sio_c_q <= 1'b1;
      oe_q    <= 1'b0;
`ifdef CFG_DELAY_EN
      dcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      qcnt_q  <= qcnt_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      frame_q <= frame_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sio_c_q <= sio_c_d;
      oe_q    <= oe_d;
`ifdef CFG_DELAY_EN
      dcnt_q  <= dcnt_d;
`endif
    end
  end

  assign bus.rom_addr = addr_q;
  assign bus.sio_c    = sio_c_q;
  assign bus.sio_d_oe = oe_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_sccb_config_sequencer.sv
// tb/tb_sccb_config_sequencer.sv - randomized table walks checked against a table-level SCCB reference model
module tb_sccb_config_sequencer;
  localparam int CLK_DIV = 2;
  localparam int DELAY   = 100;
  localparam int WR_COST = 2 + 120 * CLK_DIV;

  logic clk_25 = 1'b0;
  logic reset  = 1'b1;
  sccb_config_sequencer_if bus ();

  sccb_config_sequencer #(
    .CLK_DIV     (CLK_DIV),
    .DEV_ADDR    (8'h42),
    .DELAY_CYCLES(DELAY)
  ) dut (
    .clk_25(clk_25),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk_25 = ~clk_25;

  logic [15:0] rom [256];
  always @(posedge clk_25) bus.rom_data <= rom[bus.rom_addr];

  int unsigned cyc = 0;
  always @(posedge clk_25) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Bus decoder: start/stop detection, bit capture on SCL rise, protocol violations counted.
  logic        prev_scl = 1'b1, prev_sda = 1'b1;
  logic        in_frame = 1'b0;
  int          nbits = 0;
  logic [27:0] shreg = '0;
  int          proto_err = 0;
  int          scl_falls = 0;
  logic [23:0] frames [$];

  always @(negedge clk_25) begin
    logic scl, sda;
    scl = bus.sio_c;
    sda = ~bus.sio_d_oe;
    if (reset) begin
      in_frame = 1'b0;
      nbits    = 0;
    end else begin
      if (prev_scl && !scl) scl_falls++;
      if (prev_scl && scl && prev_sda && !sda) begin
        if (in_frame) proto_err++;
        in_frame = 1'b1;
        nbits    = 0;
        shreg    = '0;
      end else if (prev_scl && scl && !prev_sda && sda) begin
        // 27 data/ack bits plus the SCL rise that precedes the stop condition
        if (!in_frame || nbits != 28 || !shreg[19] || !shreg[10] || !shreg[1]) proto_err++;
        else frames.push_back({shreg[27:20], shreg[18:11], shreg[9:2]});
        in_frame = 1'b0;
      end else if (!prev_scl && scl) begin
        if (in_frame) begin
          shreg = {shreg[26:0], sda};
          nbits++;
        end else begin
          proto_err++;
        end
      end
    end
    prev_scl = scl;
    prev_sda = sda;
  end

  // Reference model: walk the table by its entry rules and total up cycle costs.
  logic [23:0] exp_frames [$];
  int          exp_lat;
  int          exp_last;

  task automatic build_model();
    exp_frames.delete();
    exp_lat = 0;
    for (int i = 0; i < 256; i++) begin
      exp_last = i;
      if (rom[i] == 16'hFFFF) begin
        exp_lat += 2;
        break;
      end
`ifdef CFG_DELAY_EN
      if (rom[i] == 16'hFFF0) begin
        exp_lat += 2 + DELAY;
        continue;
      end
`endif
      exp_frames.push_back({8'h42, rom[i]});
      exp_lat += WR_COST;
    end
    exp_lat += 1;
  endtask

  task automatic fill_rom(input logic [15:0] v);
    for (int i = 0; i < 256; i++) rom[i] = v;
  endtask

  task automatic run_walk(input string name, input bit poke);
    int   t0, lat, f0;
    bit   timeout, poked, left0, back0;
    build_model();
    frames.delete();
    f0 = scl_falls;
    @(negedge clk_25) bus.start = 1'b1;
    @(negedge clk_25) bus.start = 1'b0;
    t0 = cyc;
    check($sformatf("%s_busy_rise", name), bus.busy, 1'b1);
    check($sformatf("%s_addr0", name), bus.rom_addr, 8'd0);
    check($sformatf("%s_done_clr", name), bus.done, 1'b0);
    timeout = 1'b1; poked = 1'b0; left0 = 1'b0; back0 = 1'b0;
    for (int k = 0; k < exp_lat + 100; k++) begin
      if (bus.done) begin
        timeout = 1'b0;
        break;
      end
      if (bus.rom_addr != 8'd0) left0 = 1'b1;
      else if (left0) back0 = 1'b1;
      if (poke && !poked && in_frame && nbits == 3) begin
        bus.start = 1'b1;
        poked = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk_25);
    end
    bus.start = 1'b0;
    lat = cyc - t0;
    check($sformatf("%s_timeout", name), timeout, 1'b0);
    check($sformatf("%s_done_lat", name), lat, exp_lat);
    check($sformatf("%s_busy_fall", name), bus.busy, 1'b0);
    check($sformatf("%s_last_addr", name), bus.rom_addr, exp_last);
    check($sformatf("%s_no_addr_wrap", name), back0, 1'b0);
    check($sformatf("%s_nframes", name), frames.size(), exp_frames.size());
    for (int i = 0; i < exp_frames.size() && i < 8; i++)
      check($sformatf("%s_frame%0d", name, i), (i < frames.size()) ? frames[i] : 24'hxxxxxx, exp_frames[i]);
    if (name == "delay") begin
`ifdef CFG_DELAY_EN
      check("delay_no_scl", scl_falls - f0, 0);
`endif
    end
    repeat (3) @(negedge clk_25);
  endtask

  initial begin
    bit reached;
    bus.start = 1'b0;
    fill_rom(16'hFFFF);
    repeat (3) @(negedge clk_25);
    check("rst_sio_c", bus.sio_c, 1'b1);
    check("rst_sio_d_oe", bus.sio_d_oe, 1'b0);
    check("rst_rom_addr", bus.rom_addr, 8'd0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk_25);

    rom[0] = 16'h1280; rom[1] = 16'h1101; rom[2] = 16'hFFFF;
    run_walk("three", 1'b0);
    run_walk("busy_rej", 1'b1);

    fill_rom(16'hFFFF);
    rom[0] = 16'hFFF0;
    run_walk("delay", 1'b0);

    for (int r = 0; r < 3; r++) begin
      int n;
      logic [15:0] v;
      fill_rom(16'hFFFF);
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) begin
        v = 16'($urandom_range(0, 16'hFFEF));
        if ($urandom_range(0, 3) == 0) v = 16'hFFF0;
        rom[i] = v;
      end
      run_walk($sformatf("rand%0d", r), 1'b0);
    end

    fill_rom(16'hFFFF);
    rom[0] = 16'h1280; rom[1] = 16'h1101;
    @(negedge clk_25) bus.start = 1'b1;
    @(negedge clk_25) bus.start = 1'b0;
    reached = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (in_frame && nbits == 10) begin
        reached = 1'b1;
        break;
      end
      @(negedge clk_25);
    end
    check("rst_reach_bit10", reached, 1'b1);
    @(posedge clk_25);
    #2 reset = 1'b1;
    #1;
    check("midrst_sio_c", bus.sio_c, 1'b1);
    check("midrst_sio_d_oe", bus.sio_d_oe, 1'b0);
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_rom_addr", bus.rom_addr, 8'd0);
    repeat (2) @(negedge clk_25);
    @(posedge clk_25);
    #2 reset = 1'b0;
    repeat (2) @(negedge clk_25);
    run_walk("replay", 1'b0);

    fill_rom(16'h0000);
    run_walk("wrap", 1'b0);
    check("wrap_done", bus.done, 1'b1);

    check("protocol_errors", proto_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
